// File: rtl/regfile_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : regfile_pkg
//  Description : Shared sizes, arbiter state encoding and a one-hot decode
//                helper for the register-file writeback arbiter and its
//                busy scoreboard.
//  Revision    : 1.0 - initial release
// ============================================================================
package regfile_pkg;

    localparam int REG_ADDR_W = 5;
    localparam int XLEN       = 32;
    localparam int NUM_REGS   = 32;

    // Writeback arbiter states
    //   IDLE  : skid buffer empty, a slow result may be accepted
    //   HELD  : skid buffer full, fast path has priority
    //   FORCE : skid buffer full and starved, drains while the pipe stalls
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        HELD  = 2'd1,
        FORCE = 2'd2
    } arb_state_t;

    // One-hot decode of a register address into a register-wide mask.
    function automatic logic [NUM_REGS-1:0] reg_onehot(input logic [REG_ADDR_W-1:0] addr);
        logic [NUM_REGS-1:0] mask;
        mask       = '0;
        mask[addr] = 1'b1;
        return mask;
    endfunction

endpackage : regfile_pkg
`default_nettype wire

// File: rtl/reg_scoreboard.sv
`default_nettype none
// ============================================================================
//  Module      : reg_scoreboard
//  Description : Busy vector for registers with an outstanding slow write.
//                One set port, one clear port, three combinational lookups.
//  Ports       : clk, reset (async, active-high)
//                i_set_en / i_set_addr   - mark a register busy
//                i_clr_en / i_clr_addr   - mark a register free
//                i_look_{a,b,c}_addr     - lookup addresses
//                o_look_{a,b,c}_busy     - lookup results
//                o_busy_mask             - full busy vector
//  Revision    : 1.0 - initial release
// ============================================================================
module reg_scoreboard
    import regfile_pkg::*;
(
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  i_set_en,
    input  logic [REG_ADDR_W-1:0] i_set_addr,
    input  logic                  i_clr_en,
    input  logic [REG_ADDR_W-1:0] i_clr_addr,
    input  logic [REG_ADDR_W-1:0] i_look_a_addr,
    input  logic [REG_ADDR_W-1:0] i_look_b_addr,
    input  logic [REG_ADDR_W-1:0] i_look_c_addr,
    output logic                  o_look_a_busy,
    output logic                  o_look_b_busy,
    output logic                  o_look_c_busy,
    output logic [NUM_REGS-1:0]   o_busy_mask
);

    localparam logic [NUM_REGS-1:0] c_X0_MASK = {{(NUM_REGS-1){1'b0}}, 1'b1};

    logic [NUM_REGS-1:0] r_busy;
    logic [NUM_REGS-1:0] w_set_mask;
    logic [NUM_REGS-1:0] w_clr_mask;
    logic [NUM_REGS-1:0] w_busy_next;

    always_comb begin
        w_set_mask  = i_set_en ? reg_onehot(i_set_addr) : '0;
        w_clr_mask  = i_clr_en ? reg_onehot(i_clr_addr) : '0;
        // Set is applied after clear so a re-issue to a register whose write
        // commits this cycle keeps it busy. x0 can never be busy.
        w_busy_next = ((r_busy & ~w_clr_mask) | w_set_mask) & ~c_X0_MASK;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_busy <= '0;
        end else begin
            r_busy <= w_busy_next;
        end
    end

    assign o_look_a_busy = r_busy[i_look_a_addr];
    assign o_look_b_busy = r_busy[i_look_b_addr];
    assign o_look_c_busy = r_busy[i_look_c_addr];
    assign o_busy_mask   = r_busy;

endmodule : reg_scoreboard
`default_nettype wire

// File: rtl/regfile_wb_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : regfile_wb_arbiter
//  Description : Sequences all writes into the single-write-port register
//                file. Arbitrates between the fast (ALU) writeback path and a
//                one-entry skid buffer holding a slow-unit result, tracks
//                pending slow destinations and raises stall on RAW/WAW
//                hazards and on forced slow drains.
//  Ports       : clk, reset (async, active-high)
//                rs1_addr, rs2_addr            - decode source operands
//                slow_issue_valid/rd           - slow op issue
//                fast_wb_valid/addr/data       - fast writeback request
//                slow_wb_valid/ready/addr/data - slow result handshake
//                rf_should_write/addr/data     - register-file write port
//                stall                         - freeze issue/decode + fast wb
//                busy_mask                     - pending slow destinations
//  Revision    : 1.0 - initial release
// ============================================================================
module regfile_wb_arbiter
    import regfile_pkg::*;
#(
    parameter int STARVE_LIMIT = 4,
    parameter int CNT_W        = 4
)(
    input  logic                  clk,
    input  logic                  reset,
    input  logic [REG_ADDR_W-1:0] rs1_addr,
    input  logic [REG_ADDR_W-1:0] rs2_addr,
    input  logic                  slow_issue_valid,
    input  logic [REG_ADDR_W-1:0] slow_issue_rd,
    input  logic                  fast_wb_valid,
    input  logic [REG_ADDR_W-1:0] fast_wb_addr,
    input  logic [XLEN-1:0]       fast_wb_data,
    input  logic                  slow_wb_valid,
    output logic                  slow_wb_ready,
    input  logic [REG_ADDR_W-1:0] slow_wb_addr,
    input  logic [XLEN-1:0]       slow_wb_data,
    output logic                  rf_should_write,
    output logic [REG_ADDR_W-1:0] rf_write_addr,
    output logic [XLEN-1:0]       rf_write_data,
    output logic                  stall,
    output logic [NUM_REGS-1:0]   busy_mask
);

    localparam logic [CNT_W-1:0] c_STARVE = CNT_W'(STARVE_LIMIT);

    arb_state_t            r_state;
    logic [REG_ADDR_W-1:0] r_buf_addr;
    logic [XLEN-1:0]       r_buf_data;
    logic [CNT_W-1:0]      r_cnt;

    logic                  w_accept;
    logic                  w_commit_slow;
    logic                  w_fast_go;
    logic                  w_stall;
    logic                  w_rs1_busy;
    logic                  w_rs2_busy;
    logic                  w_fast_busy;
    logic                  w_issue_waw;
    logic                  w_set_en;
    logic [CNT_W-1:0]      w_cnt_inc;
    logic [NUM_REGS-1:0]   w_busy;

    reg_scoreboard u_scoreboard (
        .clk           (clk),
        .reset         (reset),
        .i_set_en      (w_set_en),
        .i_set_addr    (slow_issue_rd),
        .i_clr_en      (w_commit_slow),
        .i_clr_addr    (r_buf_addr),
        .i_look_a_addr (rs1_addr),
        .i_look_b_addr (rs2_addr),
        .i_look_c_addr (fast_wb_addr),
        .o_look_a_busy (w_rs1_busy),
        .o_look_b_busy (w_rs2_busy),
        .o_look_c_busy (w_fast_busy),
        .o_busy_mask   (w_busy)
    );

    always_comb begin
        w_accept      = slow_wb_valid & (r_state == IDLE);
        // The buffer owns the port whenever it is forced, or when it is held
        // and the fast path has nothing to write.
        w_commit_slow = (r_state == FORCE) | ((r_state == HELD) & ~fast_wb_valid);
        // A slow issue to a register whose pending write commits this very
        // cycle is not a WAW hazard: the old value lands first and the new
        // busy bit survives the clear.
        w_issue_waw   = slow_issue_valid & w_busy[slow_issue_rd] &
                        ~(w_commit_slow & (r_buf_addr == slow_issue_rd));
        w_stall       = (r_state == FORCE) | w_rs1_busy | w_rs2_busy |
                        (fast_wb_valid & w_fast_busy) | w_issue_waw;
        w_fast_go     = fast_wb_valid & ~w_stall;
        w_set_en      = slow_issue_valid & ~w_stall & (slow_issue_rd != '0);
        w_cnt_inc     = r_cnt + 1'b1;
    end

    // Register-file port: combinational within the cycle, the file latches
    // on the falling edge.
    always_comb begin
        rf_write_addr = '0;
        rf_write_data = '0;
        if (w_commit_slow) begin
            rf_write_addr = r_buf_addr;
            rf_write_data = r_buf_data;
        end else if (w_fast_go) begin
            rf_write_addr = fast_wb_addr;
            rf_write_data = fast_wb_data;
        end
        rf_should_write = (w_commit_slow | w_fast_go) & (rf_write_addr != '0);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state    <= IDLE;
            r_buf_addr <= '0;
            r_buf_data <= '0;
            r_cnt      <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_accept) begin
                        r_state    <= HELD;
                        r_buf_addr <= slow_wb_addr;
                        r_buf_data <= slow_wb_data;
                        r_cnt      <= '0;
                    end
                end
                HELD: begin
                    // Any fast request takes priority over the buffer, even
                    // one held by a stall; each such cycle counts as a loss.
                    if (fast_wb_valid) begin
                        r_cnt <= w_cnt_inc;
                        if (w_cnt_inc == c_STARVE) begin
                            r_state <= FORCE;
                        end
                    end else begin
                        r_state <= IDLE;
                    end
                end
                FORCE: begin
                    r_state <= IDLE;
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

    assign slow_wb_ready = (r_state == IDLE);
    assign stall         = w_stall;
    assign busy_mask     = w_busy;

endmodule : regfile_wb_arbiter
`default_nettype wire

// File: tb/tb_regfile_wb_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : tb_regfile_wb_arbiter
//  Description : Directed self-checking bench for regfile_wb_arbiter with
//                STARVE_LIMIT=4. Inputs change 1 ns after a rising edge and
//                outputs are sampled 1 ns later, inside the same cycle.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_regfile_wb_arbiter;

    logic        clk;
    logic        reset;
    logic [4:0]  rs1_addr;
    logic [4:0]  rs2_addr;
    logic        slow_issue_valid;
    logic [4:0]  slow_issue_rd;
    logic        fast_wb_valid;
    logic [4:0]  fast_wb_addr;
    logic [31:0] fast_wb_data;
    logic        slow_wb_valid;
    logic        slow_wb_ready;
    logic [4:0]  slow_wb_addr;
    logic [31:0] slow_wb_data;
    logic        rf_should_write;
    logic [4:0]  rf_write_addr;
    logic [31:0] rf_write_data;
    logic        stall;
    logic [31:0] busy_mask;

    int n_assert = 0;
    int n_fail   = 0;

    regfile_wb_arbiter #(
        .STARVE_LIMIT (4),
        .CNT_W        (4)
    ) dut (
        .clk              (clk),
        .reset            (reset),
        .rs1_addr         (rs1_addr),
        .rs2_addr         (rs2_addr),
        .slow_issue_valid (slow_issue_valid),
        .slow_issue_rd    (slow_issue_rd),
        .fast_wb_valid    (fast_wb_valid),
        .fast_wb_addr     (fast_wb_addr),
        .fast_wb_data     (fast_wb_data),
        .slow_wb_valid    (slow_wb_valid),
        .slow_wb_ready    (slow_wb_ready),
        .slow_wb_addr     (slow_wb_addr),
        .slow_wb_data     (slow_wb_data),
        .rf_should_write  (rf_should_write),
        .rf_write_addr    (rf_write_addr),
        .rf_write_data    (rf_write_data),
        .stall            (stall),
        .busy_mask        (busy_mask)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Advance to 1 ns after the next rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Let combinational outputs settle after driving inputs.
    task automatic settle();
        #1;
    endtask

    initial begin
        reset            = 1'b1;
        rs1_addr         = '0;
        rs2_addr         = '0;
        slow_issue_valid = 1'b0;
        slow_issue_rd    = '0;
        fast_wb_valid    = 1'b0;
        fast_wb_addr     = '0;
        fast_wb_data     = '0;
        slow_wb_valid    = 1'b0;
        slow_wb_addr     = '0;
        slow_wb_data     = '0;
        tick();
        tick();
        reset = 1'b0;
        tick();

        // ---- idle after reset ----
        settle();
        chk("rst_busy",  busy_mask,       32'h0);
        chk("rst_ready", slow_wb_ready,   32'h1);
        chk("rst_we",    rf_should_write, 32'h0);
        chk("rst_stall", stall,           32'h0);
        chk("rst_addr",  rf_write_addr,   32'h0);
        chk("rst_data",  rf_write_data,   32'h0);

        // ---- fast path only ----
        fast_wb_valid = 1'b1; fast_wb_addr = 5'd5; fast_wb_data = 32'hDEADBEEF;
        settle();
        chk("fast_we",   rf_should_write, 32'h1);
        chk("fast_addr", rf_write_addr,   32'h5);
        chk("fast_data", rf_write_data,   32'hDEADBEEF);
        fast_wb_addr = 5'd0;
        settle();
        chk("fast_x0_we",   rf_should_write, 32'h0);
        chk("fast_x0_data", rf_write_data,   32'hDEADBEEF);
        tick();
        fast_wb_valid = 1'b0;

        // ---- x0 slow issue never marks busy ----
        slow_issue_valid = 1'b1; slow_issue_rd = 5'd0;
        tick();
        slow_issue_valid = 1'b0;
        settle();
        chk("x0_issue_busy", busy_mask, 32'h0);

        // ---- slow issue rd=7, hazards, then slow writeback ----
        slow_issue_valid = 1'b1; slow_issue_rd = 5'd7;
        settle();
        chk("issue7_stall", stall, 32'h0);
        tick();
        slow_issue_valid = 1'b0;
        settle();
        chk("issue7_busy", busy_mask, 32'h0000_0080);
        rs1_addr = 5'd7;
        settle();
        chk("raw_rs1_stall", stall, 32'h1);
        rs1_addr = 5'd0;
        settle();
        chk("rs1_x0_stall", stall, 32'h0);
        rs2_addr = 5'd7;
        settle();
        chk("raw_rs2_stall", stall, 32'h1);
        rs2_addr = 5'd0;
        fast_wb_valid = 1'b1; fast_wb_addr = 5'd7; fast_wb_data = 32'h55;
        settle();
        chk("waw_fast_stall", stall,           32'h1);
        chk("waw_fast_we",    rf_should_write, 32'h0);
        fast_wb_valid = 1'b0;
        slow_wb_valid = 1'b1; slow_wb_addr = 5'd7; slow_wb_data = 32'h1234;
        settle();
        chk("hs_ready", slow_wb_ready,   32'h1);
        chk("hs_we",    rf_should_write, 32'h0);
        tick();
        slow_wb_valid = 1'b0;
        settle();
        chk("drain7_we",    rf_should_write, 32'h1);
        chk("drain7_addr",  rf_write_addr,   32'h7);
        chk("drain7_data",  rf_write_data,   32'h1234);
        chk("drain7_ready", slow_wb_ready,   32'h0);
        chk("drain7_busy",  busy_mask,       32'h0000_0080);
        tick();
        chk("post7_busy",  busy_mask,       32'h0);
        chk("post7_ready", slow_wb_ready,   32'h1);
        chk("post7_we",    rf_should_write, 32'h0);

        // ---- starvation: buffer (9, 0xAA) loses 4 times, then forced ----
        slow_issue_valid = 1'b1; slow_issue_rd = 5'd9;
        tick();
        slow_issue_valid = 1'b0;
        slow_wb_valid = 1'b1; slow_wb_addr = 5'd9; slow_wb_data = 32'hAA;
        tick();
        slow_wb_valid = 1'b0;
        for (int i = 0; i < 4; i++) begin
            fast_wb_valid = 1'b1;
            fast_wb_addr  = 5'(10 + i);
            fast_wb_data  = 32'h100 + 32'(i);
            settle();
            chk("starve_we",    rf_should_write, 32'h1);
            chk("starve_addr",  rf_write_addr,   32'(10 + i));
            chk("starve_data",  rf_write_data,   32'h100 + 32'(i));
            chk("starve_stall", stall,           32'h0);
            tick();
        end
        fast_wb_addr = 5'd14; fast_wb_data = 32'h200;
        settle();
        chk("force_stall", stall,           32'h1);
        chk("force_we",    rf_should_write, 32'h1);
        chk("force_addr",  rf_write_addr,   32'h9);
        chk("force_data",  rf_write_data,   32'hAA);
        chk("force_ready", slow_wb_ready,   32'h0);
        tick();
        chk("after_force_stall", stall,           32'h0);
        chk("after_force_we",    rf_should_write, 32'h1);
        chk("after_force_addr",  rf_write_addr,   32'hE);
        chk("after_force_data",  rf_write_data,   32'h200);
        chk("after_force_busy",  busy_mask,       32'h0);
        tick();
        fast_wb_valid = 1'b0;

        // ---- same-edge set and clear of x3: set wins ----
        slow_issue_valid = 1'b1; slow_issue_rd = 5'd3;
        tick();
        slow_issue_valid = 1'b0;
        slow_wb_valid = 1'b1; slow_wb_addr = 5'd3; slow_wb_data = 32'h33;
        tick();
        slow_wb_valid = 1'b0;
        slow_issue_valid = 1'b1; slow_issue_rd = 5'd3;
        settle();
        chk("setclr_stall", stall,           32'h0);
        chk("setclr_we",    rf_should_write, 32'h1);
        chk("setclr_addr",  rf_write_addr,   32'h3);
        tick();
        slow_issue_valid = 1'b0;
        settle();
        chk("setclr_busy", busy_mask, 32'h0000_0008);

        // ---- reset while HELD ----
        slow_wb_valid = 1'b1; slow_wb_addr = 5'd12; slow_wb_data = 32'h77;
        tick();
        slow_wb_valid = 1'b0;
        fast_wb_valid = 1'b1; fast_wb_addr = 5'd20; fast_wb_data = 32'h1;
        settle();
        chk("held_ready", slow_wb_ready, 32'h0);
        reset = 1'b1;
        fast_wb_valid = 1'b0;
        tick();
        reset = 1'b0;
        settle();
        chk("midrst_busy",  busy_mask,       32'h0);
        chk("midrst_ready", slow_wb_ready,   32'h1);
        chk("midrst_we",    rf_should_write, 32'h0);
        chk("midrst_stall", stall,           32'h0);
        tick();
        chk("midrst_nodrain_we", rf_should_write, 32'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule : tb_regfile_wb_arbiter
`default_nettype wire
